// File: rtl/cp0_timer_intc.sv
// CP0 register block for the five-stage MIPS pipeline.
// It holds BadVAddr, Count, Compare, Status, Cause and EPC, plus a prescaled
// Count/Compare timer and a synchronised, maskable interrupt request.
module cp0_timer_intc #(
    parameter int unsigned HW_INT_N  = 5,  // 1..6 external interrupt lines
    parameter int unsigned COUNT_DIV = 2,  // 1..16 clocks per Count increment
    parameter int unsigned INT_SYNC  = 1   // 1..3 synchroniser stages
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HW_INT_N-1:0] hw_int,
    input  logic                cp0_we,
    input  logic [4:0]          cp0_reg,
    input  logic [2:0]          cp0_sel,
    input  logic [31:0]         cp0_wdata,
    output logic [31:0]         cp0_rdata,
    input  logic                exc_valid,
    input  logic                exc_eret,
    input  logic [4:0]          exc_code,
    input  logic                exc_bd,
    input  logic [31:0]         exc_pc,
    input  logic [31:0]         exc_badvaddr,
    output logic [31:0]         epc,
    output logic                status_exl,
    output logic                int_req
);

    localparam logic [3:0] PRESC_MAX = 4'(COUNT_DIV - 1);

    // Architectural state
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [1:0]  sw_ip_q, sw_ip_d;
    logic [3:0]  presc_q, presc_d;
    logic        int_req_q, int_req_d;

    logic [HW_INT_N-1:0] sync_q [INT_SYNC];

    // Decoded strobes
    logic        wr_sel0;
    logic        wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        exc_commit, eret_commit;
    logic        presc_tick, count_inc;
    logic [31:0] count_plus1;
    logic [5:0]  hw_ext;
    logic [7:0]  ip;
    logic [31:0] status_val, cause_val;

    // Write decode, commit qualification and Cause.IP assembly
    always_comb begin
        wr_sel0     = cp0_we && (cp0_sel == 3'd0);
        wr_badvaddr = wr_sel0 && (cp0_reg == 5'd8);
        wr_count    = wr_sel0 && (cp0_reg == 5'd9);
        wr_compare  = wr_sel0 && (cp0_reg == 5'd11);
        wr_status   = wr_sel0 && (cp0_reg == 5'd12);
        wr_cause    = wr_sel0 && (cp0_reg == 5'd13);
        wr_epc      = wr_sel0 && (cp0_reg == 5'd14);

        exc_commit  = exc_valid && !exc_eret;
        eret_commit = exc_valid && exc_eret;

        presc_tick  = (presc_q == PRESC_MAX);
        // A Count write in the same cycle replaces the increment
        count_inc   = presc_tick && !wr_count;
        count_plus1 = count_q + 32'd1;

        // Unused lines zero-extend; line 5 only exists when HW_INT_N is 6
        hw_ext = 6'(sync_q[INT_SYNC-1]);
        ip     = {ti_q | hw_ext[5], hw_ext[4:0], sw_ip_q};

        status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
        cause_val  = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
    end

    // Next-state logic; hardware commits win over MTC0 on the same field
    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        exc_code_d = exc_code_q;
        sw_ip_d    = sw_ip_q;
        presc_d    = presc_q + 4'd1;

        // Timer
        if (wr_count) begin
            count_d = cp0_wdata;
            presc_d = 4'd0;
        end else if (presc_tick) begin
            count_d = count_plus1;
            presc_d = 4'd0;
        end
        if (wr_compare) begin
            compare_d = cp0_wdata;
        end
        if (wr_compare) begin
            ti_d = 1'b0;
        end else if (count_inc && (count_plus1 == compare_q)) begin
            ti_d = 1'b1;
        end

        // MTC0 writes
        if (wr_badvaddr) badvaddr_d = cp0_wdata;
        if (wr_epc)      epc_d      = cp0_wdata;
        if (wr_cause)    sw_ip_d    = cp0_wdata[9:8];
        if (wr_status) begin
            im_d  = cp0_wdata[15:8];
            exl_d = cp0_wdata[1];
            ie_d  = cp0_wdata[0];
        end

        // Hardware commits override the MTC0 values above
        if (exc_commit) begin
            exl_d      = 1'b1;
            exc_code_d = exc_code;
            if (!exl_q) begin
                epc_d = exc_pc;
                bd_d  = exc_bd;
            end
            if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret_commit) begin
            exl_d = 1'b0;
        end

        int_req_d = ie_q && !exl_q && (|(ip & im_q));
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            exc_code_q <= '0;
            sw_ip_q    <= '0;
            presc_q    <= '0;
            int_req_q  <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            exc_code_q <= exc_code_d;
            sw_ip_q    <= sw_ip_d;
            presc_q    <= presc_d;
            int_req_q  <= int_req_d;
        end
    end

    // Interrupt synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < INT_SYNC; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= hw_int;
            for (int k = 1; k < INT_SYNC; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // MFC0 read mux; no bypass of same-cycle writes
    always_comb begin
        cp0_rdata = 32'd0;
        if (cp0_sel == 3'd0) begin
            case (cp0_reg)
                5'd8:    cp0_rdata = badvaddr_q;
                5'd9:    cp0_rdata = count_q;
                5'd11:   cp0_rdata = compare_q;
                5'd12:   cp0_rdata = status_val;
                5'd13:   cp0_rdata = cause_val;
                5'd14:   cp0_rdata = epc_q;
                default: cp0_rdata = 32'd0;
            endcase
        end
    end

    assign epc        = epc_q;
    assign status_exl = exl_q;
    assign int_req    = int_req_q;

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed self-checking bench for cp0_timer_intc (HW_INT_N=6, COUNT_DIV=2, INT_SYNC=2).
module tb_cp0_timer_intc;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_reg;
    logic [2:0]  cp0_sel;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        exc_valid;
    logic        exc_eret;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_pc;
    logic [31:0] exc_badvaddr;
    logic [31:0] epc;
    logic        status_exl;
    logic        int_req;

    int checks   = 0;
    int failures = 0;
    logic [31:0] d;

    cp0_timer_intc #(
        .HW_INT_N (6),
        .COUNT_DIV(2),
        .INT_SYNC (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hw_int      (hw_int),
        .cp0_we      (cp0_we),
        .cp0_reg     (cp0_reg),
        .cp0_sel     (cp0_sel),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .exc_valid   (exc_valid),
        .exc_eret    (exc_eret),
        .exc_code    (exc_code),
        .exc_bd      (exc_bd),
        .exc_pc      (exc_pc),
        .exc_badvaddr(exc_badvaddr),
        .epc         (epc),
        .status_exl  (status_exl),
        .int_req     (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] r, input logic [2:0] s, output logic [31:0] v);
        cp0_reg = r;
        cp0_sel = s;
        #1;
        v = cp0_rdata;
    endtask

    task automatic wr(input logic [4:0] r, input logic [2:0] s, input logic [31:0] v);
        cp0_we    = 1'b1;
        cp0_reg   = r;
        cp0_sel   = s;
        cp0_wdata = v;
        tick();
        cp0_we    = 1'b0;
    endtask

    task automatic exc(input logic eret, input logic [4:0] code, input logic [31:0] pc,
                       input logic bd, input logic [31:0] bva);
        exc_valid    = 1'b1;
        exc_eret     = eret;
        exc_code     = code;
        exc_pc       = pc;
        exc_bd       = bd;
        exc_badvaddr = bva;
        tick();
        exc_valid    = 1'b0;
        exc_eret     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hw_int = '0; cp0_we = 1'b0; cp0_reg = '0; cp0_sel = '0;
        cp0_wdata = '0; exc_valid = 1'b0; exc_eret = 1'b0; exc_code = '0;
        exc_bd = 1'b0; exc_pc = '0; exc_badvaddr = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        rd(5'd8,  3'd0, d); chk("rst_badvaddr", d, 32'h0);
        rd(5'd9,  3'd0, d); chk("rst_count",    d, 32'h0);
        rd(5'd11, 3'd0, d); chk("rst_compare",  d, 32'h0);
        rd(5'd12, 3'd0, d); chk("rst_status",   d, 32'h0040_0000);
        rd(5'd13, 3'd0, d); chk("rst_cause",    d, 32'h0);
        rd(5'd14, 3'd0, d); chk("rst_epc",      d, 32'h0);
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_exl", {31'b0, status_exl}, 32'h0);

        // Timer: Compare=5, enable IM7/IE, clear Count, match ten cycles later
        wr(5'd11, 3'd0, 32'd5);
        wr(5'd12, 3'd0, 32'h0000_8001);
        wr(5'd9,  3'd0, 32'd0);
        repeat (9) tick();
        rd(5'd9,  3'd0, d); chk("tmr_count_pre", d, 32'd4);
        rd(5'd13, 3'd0, d); chk("tmr_cause_pre", d, 32'h0);
        tick();
        rd(5'd9,  3'd0, d); chk("tmr_count_match", d, 32'd5);
        rd(5'd13, 3'd0, d); chk("tmr_cause_ti", d, 32'h4000_8000);
        chk("tmr_int_req_lag", {31'b0, int_req}, 32'h0);
        tick();
        chk("tmr_int_req_up", {31'b0, int_req}, 32'h1);
        wr(5'd11, 3'd0, 32'd9);
        rd(5'd13, 3'd0, d); chk("tmr_ti_clear", d, 32'h0);
        tick();
        chk("tmr_int_req_down", {31'b0, int_req}, 32'h0);
        wr(5'd11, 3'd0, 32'h0FFF_FFFF);
        wr(5'd12, 3'd0, 32'h0);

        // Nested exceptions and ERET
        exc(1'b0, 5'd4, 32'h8000_0100, 1'b1, 32'h13);
        chk("exc1_epc", epc, 32'h8000_0100);
        chk("exc1_exl", {31'b0, status_exl}, 32'h1);
        rd(5'd8,  3'd0, d); chk("exc1_badvaddr", d, 32'h13);
        rd(5'd13, 3'd0, d); chk("exc1_cause", d, 32'h8000_0010);
        exc(1'b0, 5'd8, 32'h200, 1'b0, 32'h99);
        chk("exc2_epc", epc, 32'h8000_0100);
        rd(5'd13, 3'd0, d); chk("exc2_cause", d, 32'h8000_0020);
        rd(5'd8,  3'd0, d); chk("exc2_badvaddr", d, 32'h13);
        exc(1'b1, 5'd0, 32'h0, 1'b0, 32'h0);
        chk("eret_exl", {31'b0, status_exl}, 32'h0);
        rd(5'd12, 3'd0, d); chk("eret_status", d, 32'h0040_0000);

        // Synchroniser and masking
        hw_int = 6'b000100;
        tick();
        rd(5'd13, 3'd0, d); chk("sync_ip_1cyc", (d >> 8) & 32'hFF, 32'h00);
        tick();
        rd(5'd13, 3'd0, d); chk("sync_ip_2cyc", (d >> 8) & 32'hFF, 32'h10);
        tick();
        chk("mask_int_req_im0", {31'b0, int_req}, 32'h0);
        wr(5'd12, 3'd0, 32'h0000_1001);
        chk("mask_int_req_lag", {31'b0, int_req}, 32'h0);
        tick();
        chk("mask_int_req_up", {31'b0, int_req}, 32'h1);
        hw_int = 6'b100000;
        wr(5'd12, 3'd0, 32'h0);
        tick();
        rd(5'd13, 3'd0, d); chk("hw5_ip7", (d >> 8) & 32'hFF, 32'h80);
        hw_int = 6'b0;
        tick();
        tick();
        wr(5'd13, 3'd0, 32'hFFFF_FFFF);
        rd(5'd13, 3'd0, d); chk("cause_sw_only", d, 32'h8000_0320);
        wr(5'd13, 3'd0, 32'h0);

        // Same-cycle EPC conflict: hardware wins, read shows old value
        cp0_we = 1'b1; cp0_reg = 5'd14; cp0_sel = 3'd0; cp0_wdata = 32'hAAAA_AAAA;
        exc_valid = 1'b1; exc_eret = 1'b0; exc_code = 5'd8; exc_pc = 32'h1234;
        exc_bd = 1'b0; exc_badvaddr = 32'h0;
        #1;
        chk("no_bypass_epc", cp0_rdata, 32'h8000_0100);
        tick();
        cp0_we = 1'b0; exc_valid = 1'b0;
        chk("conflict_epc", epc, 32'h1234);
        exc(1'b1, 5'd0, 32'h0, 1'b0, 32'h0);
        wr(5'd14, 3'd0, 32'hAAAA_AAAA);
        rd(5'd14, 3'd0, d); chk("mtc0_epc", d, 32'hAAAA_AAAA);
        wr(5'd14, 3'd1, 32'h55);
        rd(5'd14, 3'd0, d); chk("sel1_write_ignored", d, 32'hAAAA_AAAA);
        rd(5'd12, 3'd1, d); chk("sel1_read_zero", d, 32'h0);
        rd(5'd15, 3'd0, d); chk("reg15_read_zero", d, 32'h0);

        // Count write on an increment cycle, then wrap with match at 0
        wr(5'd11, 3'd0, 32'h0);
        wr(5'd9,  3'd0, 32'h0);
        tick();
        wr(5'd9,  3'd0, 32'hFFFF_FFFF);
        rd(5'd9,  3'd0, d); chk("count_write_wins", d, 32'hFFFF_FFFF);
        tick();
        rd(5'd9,  3'd0, d); chk("count_hold", d, 32'hFFFF_FFFF);
        rd(5'd13, 3'd0, d); chk("ti_before_wrap", (d >> 30) & 32'h1, 32'h0);
        tick();
        rd(5'd9,  3'd0, d); chk("count_wrap", d, 32'h0);
        rd(5'd13, 3'd0, d); chk("ti_at_zero", (d >> 30) & 32'h1, 32'h1);
        wr(5'd12, 3'd0, 32'h0000_8001);
        tick();
        chk("wrap_int_req", {31'b0, int_req}, 32'h1);

        // Mid-operation reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_int_req", {31'b0, int_req}, 32'h0);
        chk("mrst_epc", epc, 32'h0);
        rd(5'd13, 3'd0, d); chk("mrst_cause", d, 32'h0);
        rd(5'd12, 3'd0, d); chk("mrst_status", d, 32'h0040_0000);
        rd(5'd9,  3'd0, d); chk("mrst_count", d, 32'h0);
        tick();
        tick();
        rd(5'd9,  3'd0, d); chk("mrst_count_run", d, 32'h1);
        rd(5'd13, 3'd0, d); chk("mrst_no_ti", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_timer_intc.md
# cp0_timer_intc

Parametrised CP0 register block with an integrated Count/Compare timer and a maskable interrupt controller for the five-stage MIPS pipeline. It holds BadVAddr, Count, Compare, Status, Cause and EPC and serves MTC0/MFC0 from the EX stage. It records exceptions and ERET committed by the MEM stage, and raises a single interrupt request to the IF stage. Compared with the fixed CP0 logic it replaces, it adds:

- a configurable hardware-interrupt count;
- a Count prescaler;
- an interrupt synchroniser;
- a real Cause.TI bit.

## Interface
Parameters:
- HW_INT_N, 5: number of external interrupt lines, range 1..6. Line i maps to Cause.IP[2+i].
- COUNT_DIV, 2: Count increments once every COUNT_DIV clocks, range 1..16.
- INT_SYNC, 1: number of flop stages on hw_int before Cause.IP, range 1..3.

Ports:
- clk  in  1  clock. Everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- hw_int  in  HW_INT_N  level-sensitive external interrupts, asynchronous to the pipeline.
- cp0_we  in  1  MTC0 write strobe.
- cp0_reg  in  5  register number, used for both read and write.
- cp0_sel  in  3  select field. Only sel 0 is implemented.
- cp0_wdata  in  32  MTC0 data.
- cp0_rdata  out  32  MFC0 data, combinational from cp0_reg/cp0_sel.
- exc_valid  in  1  an exception or ERET commits this cycle.
- exc_eret  in  1  qualifies exc_valid as ERET.
- exc_code  in  5  ExcCode of the committing exception.
- exc_bd  in  1  the faulting instruction is in a delay slot.
- exc_pc  in  32  EPC candidate, already corrected for the delay slot.
- exc_badvaddr  in  32  faulting address, used only for AdEL (4) and AdES (5).
- epc  out  32  current EPC, used as the ERET target.
- status_exl  out  1  Status.EXL.
- int_req  out  1  registered interrupt request.

## Operation
Register layout (sel 0):
- 8 BadVAddr.
- 9 Count.
- 11 Compare.
- 12 Status = {9'b0, BEV=1, 6'b0, IM[7:0], 6'b0, EXL, IE}.
- 13 Cause = {BD, TI, 14'b0, IP[7:0], 1'b0, ExcCode, 2'b0}.
- 14 EPC.
- Any other reg/sel reads as 0. Writes to it are ignored.

Writable fields:
- BadVAddr, Count, Compare, EPC: all 32 bits.
- Status: IM, EXL, IE.
- Cause: IP[1:0] only.
- All other bits are read-only.

Cause.IP assembly:
- IP[1:0]: software interrupt bits.
- IP[2+i]: synchronised hw_int[i], for i < HW_INT_N and 2+i < 7. Unused IP bits read 0.
- IP[7]: TI, ORed with synchronised hw_int[5] when HW_INT_N = 6.

Timer:
- A prescaler counts 0..COUNT_DIV-1 and wraps.
- Count increments by 1 (modulo 2^32) on each cycle where the prescaler equals COUNT_DIV-1.
- An MTC0 write to Count loads Count and clears the prescaler. That write overrides the increment in the same cycle.
- TI sets on an increment whose new Count value equals Compare.
- TI clears on any MTC0 write to Compare. The clear wins over a set in the same cycle.
- Reset does not set TI, even though Count = Compare = 0.

Exception commit (exc_valid=1, exc_eret=0):
- EXL <= 1.
- ExcCode <= exc_code.
- If EXL was 0: EPC <= exc_pc and BD <= exc_bd. If EXL was already 1, EPC and BD hold.
- BadVAddr <= exc_badvaddr, only when exc_code is 4 or 5.

ERET commit (exc_valid=1, exc_eret=1):
- EXL <= 0. Nothing else changes.

Write priority:
- When a hardware commit and an MTC0 write target the same field in the same cycle, the hardware update wins. The MTC0 write to other fields still takes effect.

Interrupt request:
- int_req is registered: int_req <= IE & ~EXL & |(IP & IM).

## Timing
- Reset state:
  - All registers are 0, except Status.BEV which reads 1.
  - Prescaler 0, synchroniser flops 0.
  - int_req = 0, epc = 0, status_exl = 0.
  - cp0_rdata is 0 for every register except Status, which reads 0x0040_0000.
- MTC0: the value is visible to MFC0 on the cycle after cp0_we.
- cp0_rdata is combinational. In the cycle of a write it returns the old value; there is no bypass.
- External interrupt latency: hw_int rising to Cause.IP visible is INT_SYNC cycles. int_req follows one cycle later.
- Timer interrupt latency: the increment that matches Compare sets TI at that edge. int_req rises one cycle later.
- Count increments on cycles COUNT_DIV, 2·COUNT_DIV, ... after reset deasserts.
- Count wraps from 0xFFFF_FFFF to 0 and continues. A match at 0 is valid.
- Reset asserted mid-operation returns everything to the reset state at the next edge and discards any pending TI.

## Test plan
- **Reset:** reset 3 cycles, then read regs 8/9/11/12/13/14 → 0, 0, 0, 0x0040_0000, 0, 0; int_req = 0.
- **Timer (COUNT_DIV=2):**
  - Write Compare=5.
  - Count reaches 5 ten cycles after its clear → TI=1, Cause reads 0x4000_8000.
  - int_req rises once Status=0x0000_8001.
  - Write Compare=9 → TI=0 the next cycle.
- **Nested exceptions:**
  - exc_valid with code 4, pc 0x8000_0100, bd=1, badvaddr 0x13 → EPC=0x8000_0100, BD=1, BadVAddr=0x13, EXL=1.
  - A second exception with code 8 and pc 0x200 → EPC unchanged, ExcCode=8.
  - ERET → EXL=0.
- **Synchroniser and masking (INT_SYNC=2, HW_INT_N=6):**
  - Pulse hw_int[2] → IP[4] set after 2 cycles.
  - int_req stays 0 with IM=0x00.
  - Set IM=0x10 and IE=1 → int_req rises one cycle later.
- **Same-cycle conflict:** MTC0 EPC=0xAAAA_AAAA in the same cycle as an exception with pc 0x1234 → EPC=0x1234.
- **Count write collision and wrap:**
  - MTC0 Count=0xFFFF_FFFF on a prescaler-increment cycle → Count reads 0xFFFF_FFFF.
  - After COUNT_DIV more cycles → Count reads 0.
